// File: rtl/ql_carry_chain_pipe_if.sv
// Operand/result handshake bundle for the pipelined P/G carry chain.
interface ql_carry_chain_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             ci;
  logic             ci_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output in_valid, p, g, ci, ci_sel, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
    input  in_valid, p, g, ci, ci_sel, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/ql_carry_chain_pipe.sv
// Pipelined fabric carry chain: WIDTH P/G cells rippled SEG bits per register stage,
// with valid/ready flow control and optional chaining of the last consumed carry-out.
module ql_carry_chain_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  ql_carry_chain_pipe_if.slave    bus
);
  localparam int NSEG = WIDTH / SEG;

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("ql_carry_chain_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic [NSEG-1:0] vld;
  logic            adv;
  logic            ci_res;
  logic            chain_c_q;
  logic            chain_c_d;

  // Whole pipe advances as one; only a stalled, valid output can hold it.
  assign adv          = !vld[NSEG-1] | bus.out_ready;
  assign bus.in_ready = adv;
  assign ci_res       = bus.ci_sel ? chain_c_q : bus.ci;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int HI = WIDTH - LO;

    logic              v_in;
    logic              c_in;
    logic [HI-1:0]     p_in;
    logic [HI-1:0]     g_in;
    logic [SEG:0]      c_rip;
    logic [SEG-1:0]    s_slice;
    logic [LO+SEG-1:0] s_nxt;
    logic              vld_q;
    logic              c_q;
    logic [LO+SEG-1:0] s_q;

    if (k == 0) begin : g_head
      assign v_in  = bus.in_valid;
      assign c_in  = ci_res;
      assign p_in  = bus.p;
      assign g_in  = bus.g;
      assign s_nxt = s_slice;
    end else begin : g_body
      assign v_in  = g_stg[k-1].vld_q;
      assign c_in  = g_stg[k-1].c_q;
      assign p_in  = g_stg[k-1].g_fwd.pr_q;
      assign g_in  = g_stg[k-1].g_fwd.gr_q;
      assign s_nxt = {s_slice, g_stg[k-1].s_q};
    end

    assign c_rip[0] = c_in;
    for (genvar b = 0; b < SEG; b++) begin : g_bit
      assign s_slice[b]  = p_in[b] ^ c_rip[b];
      assign c_rip[b+1]  = p_in[b] ? c_rip[b] : g_in[b];
    end

    assign vld[k] = vld_q;

    // Data registers load only on real beats so bubbles leave the last result visible.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= v_in;
        if (v_in) begin
          c_q <= c_rip[SEG];
          s_q <= s_nxt;
        end
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [HI-SEG-1:0] pr_q;
      logic [HI-SEG-1:0] gr_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pr_q <= '0;
          gr_q <= '0;
        end else if (adv && v_in) begin
          pr_q <= p_in[HI-1:SEG];
          gr_q <= g_in[HI-1:SEG];
        end
      end
    end
  end

  assign bus.out_valid = g_stg[NSEG-1].vld_q;
  assign bus.sum       = g_stg[NSEG-1].s_q;
  assign bus.co        = g_stg[NSEG-1].c_q;

  // Chain carry follows consumed results only, never beats still in flight.
  assign chain_c_d = (bus.out_valid && bus.out_ready) ? bus.co : chain_c_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_c_q <= 1'b0;
    end else begin
      chain_c_q <= chain_c_d;
    end
  end
endmodule
